sub_bytes_seq: RTL and testbench

Sequential, parametrised AES SubBytes / InvSubBytes engine. Accepts one 128-bit state over a valid/ready handshake. Substitutes LANES bytes per clock through LANES byte-lookup instances, then presents the result over a second valid/ready handshake. It sits between the round-key adder and ShiftRows in the iterative encrypt/decrypt datapath. It replaces the fully parallel 16-lookup substitution where area matters, and adds inverse mode for the decryption path.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/sbox_byte.sv | 15 +
 rtl/sub_bytes_seq.sv | 133 +++++++++++++
 tb/tb_sub_bytes_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte S-box tables, block geometry and the iterative-block state enum.
package aes_pkg;

    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = 16;

    // Common control states of the iterative AES datapath blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Forward S-box, indexed by {row, col} = {high nibble, low nibble}.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse S-box, same indexing.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_byte.sv
// Single-byte combinational S-box / inverse S-box lookup.
module sbox_byte
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_inv,
    output logic [BYTE_W-1:0] o_byte_c
);

    // Table select on mode; the byte value is the row/column index.
    always_comb begin
        o_byte_c = i_inv ? INV_SBOX[i_byte] : SBOX[i_byte];
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative SubBytes/InvSubBytes: LANES bytes substituted in place per cycle, valid/ready on both sides.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    localparam int unsigned N_STEPS = NUM_BYTES / LANES;
    localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int unsigned LANE_SH = $clog2(LANES);
    localparam int unsigned IDX_W   = $clog2(NUM_BYTES);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    aes_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_inv;
    logic [BLOCK_W-1:0] r_data;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [IDX_W-1:0]   w_base;
    logic [BYTE_W-1:0]  w_bytes      [NUM_BYTES];
    logic [BYTE_W-1:0]  w_bytes_next [NUM_BYTES];
    logic [BYTE_W-1:0]  w_lane_in    [LANES];
    logic [BYTE_W-1:0]  w_lane_out   [LANES];
    logic [BLOCK_W-1:0] w_data_next;

    // Split the state into bytes and pick the LANES bytes addressed by the current step.
    always_comb begin
        w_base = IDX_W'(r_cnt) << LANE_SH;
        for (int unsigned k = 0; k < NUM_BYTES; k++) begin
            w_bytes[k] = r_data[BLOCK_W-1-BYTE_W*k -: BYTE_W];
        end
        for (int unsigned l = 0; l < LANES; l++) begin
            w_lane_in[l] = w_bytes[w_base + IDX_W'(l)];
        end
    end

    // One lookup per lane, all sharing the mode latched at accept.
    generate
        for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
            sbox_byte u_sbox (
                .i_byte   (w_lane_in[g]),
                .i_inv    (r_inv),
                .o_byte_c (w_lane_out[g])
            );
        end
    endgenerate

    // Write substituted bytes back into their slots; all other bytes pass through.
    always_comb begin
        w_bytes_next = w_bytes;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_bytes_next[w_base + IDX_W'(l)] = w_lane_out[l];
        end
        w_data_next = '0;
        for (int unsigned k = 0; k < NUM_BYTES; k++) begin
            w_data_next[BLOCK_W-1-BYTE_W*k -: BYTE_W] = w_bytes_next[k];
        end
    end

    // Control FSM with state register, step counter and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_inv       <= 1'b0;
            r_data      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data     <= in_data;
                        r_inv      <= in_inv;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_data <= w_data_next;
                    if (r_cnt == CNT_W'(N_STEPS - 1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_data  = r_data;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench: four engines (LANES 4, 1, 16, 2) against a GF(2^8)-derived transaction model.
module tb_sub_bytes_seq;

    localparam int unsigned NI = 4;
    localparam int unsigned LANES_T [NI] = '{4, 1, 16, 2};
    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [NI];
    logic         in_valid  [NI];
    logic         in_inv    [NI];
    logic         out_ready [NI];
    logic [127:0] in_data   [NI];
    wire          in_ready  [NI];
    wire          out_valid [NI];
    wire          busy      [NI];
    wire  [127:0] out_data  [NI];

    generate
        for (genvar g = 0; g < int'(NI); g++) begin : g_dut
            sub_bytes_seq #(.LANES(LANES_T[g])) u_dut (
                .clk       (clk),
                .rst       (rst[g]),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_data   (in_data[g]),
                .in_inv    (in_inv[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference tables derived from field inversion plus the affine map.
    logic [7:0] m_sbox  [256];
    logic [7:0] m_isbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(a, 8'(y)) == 8'h01) r = 8'(y);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b};
        return w[15-n -: 8];
    endfunction

    task automatic build_tables();
        logic [7:0] iv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            iv = ginv(8'(x));
            s  = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
            m_sbox[x]  = s;
            m_isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_sub(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = d[127-8*k -: 8];
            r[127-8*k -: 8] = inv ? m_isbox[b] : m_sbox[b];
        end
        return r;
    endfunction

    // Transaction model: accepted block finishes 16/LANES edges later, held until out_ready.
    int           m_rem  [NI] = '{default: 0};
    logic         m_done [NI] = '{default: 1'b0};
    logic [127:0] m_exp  [NI] = '{default: '0};

    always @(posedge clk) begin
        for (int i = 0; i < int'(NI); i++) begin
            if (rst[i]) begin
                m_rem[i]  <= 0;
                m_done[i] <= 1'b0;
            end else if (m_rem[i] != 0) begin
                m_rem[i] <= m_rem[i] - 1;
                if (m_rem[i] == 1) m_done[i] <= 1'b1;
            end else if (m_done[i]) begin
                if (out_ready[i]) m_done[i] <= 1'b0;
            end else if (in_valid[i]) begin
                m_rem[i] <= int'(16 / LANES_T[i]);
                m_exp[i] <= model_sub(in_data[i], in_inv[i]);
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Per-cycle comparison of every engine against the model.
    task automatic compare_all();
        logic mb;
        for (int i = 0; i < int'(NI); i++) begin
            if (rst[i]) begin
                check_bit($sformatf("cmp%0d.rst.in_ready", i), in_ready[i], 1'b1);
                check_bit($sformatf("cmp%0d.rst.out_valid", i), out_valid[i], 1'b0);
                check_bit($sformatf("cmp%0d.rst.busy", i), busy[i], 1'b0);
                check($sformatf("cmp%0d.rst.out_data", i), out_data[i], 128'h0);
            end else begin
                mb = (m_rem[i] != 0) || m_done[i];
                check_bit($sformatf("cmp%0d.in_ready", i), in_ready[i], !mb);
                check_bit($sformatf("cmp%0d.out_valid", i), out_valid[i], m_done[i]);
                check_bit($sformatf("cmp%0d.busy", i), busy[i], mb);
                if (m_done[i]) check($sformatf("cmp%0d.out_data", i), out_data[i], m_exp[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block, measure latency, check the result, then complete the handshake.
    task automatic run_block(input int i, input logic [127:0] d, input logic inv,
                             input logic [127:0] exp, input int lat, input string nm);
        int n;
        check_bit({nm, ".ready_before"}, in_ready[i], 1'b1);
        in_data[i]  = d;
        in_inv[i]   = inv;
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
        n = 0;
        while (!out_valid[i] && n < 200) begin
            tick();
            n++;
        end
        check_int({nm, ".latency"}, n, lat);
        check({nm, ".data"}, out_data[i], exp);
        tick();
        check_bit({nm, ".ready_after"}, in_ready[i], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rises [3];
        int nr;
        logic prev;

        build_tables();
        for (int i = 0; i < int'(NI); i++) begin
            rst[i] = 1'b1; in_valid[i] = 1'b0; in_inv[i] = 1'b0;
            in_data[i] = '0; out_ready[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < int'(NI); i++) begin
            check_bit($sformatf("reset%0d.in_ready", i), in_ready[i], 1'b1);
            check_bit($sformatf("reset%0d.out_valid", i), out_valid[i], 1'b0);
            check_bit($sformatf("reset%0d.busy", i), busy[i], 1'b0);
            check($sformatf("reset%0d.out_data", i), out_data[i], 128'h0);
        end

        // Pin the reference model to known FIPS-197 values.
        check("model.fwd_fips", model_sub(FIPS_IN, 1'b0), FIPS_OUT);
        check("model.inv_fips", model_sub(FIPS_OUT, 1'b1), FIPS_IN);
        check("model.sbox53", 128'(m_sbox[8'h53]), 128'hed);
        check("model.isbox63", 128'(m_isbox[8'h63]), 128'h00);

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < int'(NI); i++) rst[i] = 1'b0;
        tick();

        // Forward vector and inverse round-trips across lane widths.
        run_block(0, FIPS_IN, 1'b0, FIPS_OUT, 4, "fwd_l4");
        run_block(1, FIPS_OUT, 1'b1, FIPS_IN, 16, "inv_l1");
        run_block(2, FIPS_OUT, 1'b1, FIPS_IN, 1, "inv_l16");
        run_block(2, FIPS_IN, 1'b0, FIPS_OUT, 1, "fwd_l16");

        // Single-byte corners.
        run_block(0, {16{8'h00}}, 1'b0, {16{8'h63}}, 4, "corner00");
        run_block(0, {16{8'h53}}, 1'b0, {16{8'hed}}, 4, "corner53");
        run_block(0, {16{8'h63}}, 1'b1, {16{8'h00}}, 4, "corner63inv");

        // Back-pressure: stall in DONE for 10 cycles with a spurious in_valid.
        out_ready[0] = 1'b0;
        in_data[0] = FIPS_IN; in_inv[0] = 1'b0; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 200) begin tick(); n++; end
        check_int("bp.latency", n, 4);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin in_data[0] = '0; in_inv[0] = 1'b1; in_valid[0] = 1'b1; end
            if (c == 6) in_valid[0] = 1'b0;
            tick();
            check($sformatf("bp.hold%0d", c), out_data[0], FIPS_OUT);
            check_bit($sformatf("bp.ready%0d", c), in_ready[0], 1'b0);
        end
        out_ready[0] = 1'b1;
        tick();
        check_bit("bp.release_ready", in_ready[0], 1'b1);
        check_bit("bp.release_valid", out_valid[0], 1'b0);

        // Back-to-back blocks with in_valid held and out_ready high.
        in_data[0] = {16{8'h53}}; in_inv[0] = 1'b0; in_valid[0] = 1'b1;
        nr = 0; prev = out_valid[0];
        rises = '{default: 0};
        for (int t = 0; t < 40 && nr < 3; t++) begin
            tick();
            if (out_valid[0] && !prev) begin
                rises[nr] = cyc;
                nr++;
                check("b2b.data", out_data[0], {16{8'hed}});
            end
            prev = out_valid[0];
        end
        in_valid[0] = 1'b0;
        check_int("b2b.gap1", rises[1] - rises[0], 6);
        check_int("b2b.gap2", rises[2] - rises[1], 6);
        n = 0;
        while (!in_ready[0] && n < 50) begin tick(); n++; end
        check_bit("b2b.idle", in_ready[0], 1'b1);

        // Reset mid-RUN at cnt=2 with LANES=2.
        in_data[3] = FIPS_IN; in_inv[3] = 1'b0; in_valid[3] = 1'b1;
        tick();
        in_valid[3] = 1'b0;
        tick(); tick();
        #2;
        rst[3] = 1'b1;
        #1;
        check_bit("rstrun.out_valid", out_valid[3], 1'b0);
        check_bit("rstrun.in_ready", in_ready[3], 1'b1);
        check_bit("rstrun.busy", busy[3], 1'b0);
        check("rstrun.out_data", out_data[3], 128'h0);
        tick();
        rst[3] = 1'b0;
        run_block(3, FIPS_IN, 1'b0, FIPS_OUT, 8, "after_rst_l2");

        // Mode latch: in_inv toggles every RUN cycle, result follows the accepted mode.
        in_data[1] = FIPS_IN; in_inv[1] = 1'b0; in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        n = 0;
        while (!out_valid[1] && n < 200) begin
            in_inv[1] = ~in_inv[1];
            tick();
            n++;
        end
        check_int("mode.latency", n, 16);
        check("mode.data", out_data[1], FIPS_OUT);
        in_inv[1] = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
